// File: rtl/vec_elem_sequencer_if.sv
// Command and register-file port bundle for vec_elem_sequencer.
// The slave modport is the sequencer; the master modport is the command source plus register file.
interface vec_elem_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_vd;
    logic [ADDR_WIDTH-1:0] cmd_vs1;
    logic [ADDR_WIDTH-1:0] cmd_vs2;
    logic [ADDR_WIDTH:0]   cmd_vl;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [ADDR_WIDTH-1:0] rf_rAddr1_1;
    logic [ADDR_WIDTH-1:0] rf_rAddr2_1;
    logic [ADDR_WIDTH-1:0] rf_rAddr1_2;
    logic [ADDR_WIDTH-1:0] rf_rAddr2_2;
    logic [DATA_WIDTH-1:0] rf_rData1;
    logic [DATA_WIDTH-1:0] rf_rData2;
    logic [ADDR_WIDTH-1:0] rf_wAddr1;
    logic [ADDR_WIDTH-1:0] rf_wAddr2;
    logic [DATA_WIDTH-1:0] rf_wData;
    logic                  rf_wEnable;

    modport slave (
        input  cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl, rf_rData1, rf_rData2,
        output cmd_ready, busy, done, err,
        output rf_rAddr1_1, rf_rAddr2_1, rf_rAddr1_2, rf_rAddr2_2,
        output rf_wAddr1, rf_wAddr2, rf_wData, rf_wEnable
    );

    modport master (
        output cmd_valid, cmd_op, cmd_vd, cmd_vs1, cmd_vs2, cmd_vl, rf_rData1, rf_rData2,
        input  cmd_ready, busy, done, err,
        input  rf_rAddr1_1, rf_rAddr2_1, rf_rAddr1_2, rf_rAddr2_2,
        input  rf_wAddr1, rf_wAddr2, rf_wData, rf_wEnable
    );
endinterface

// File: rtl/vec_elem_sequencer.sv
// Element-serial vector ALU sequencer: one element read per cycle, written back one cycle later.
// Define VEC_SEQ_MUL_EN to build the multiplier for op 5; otherwise op 5 is rejected with err.
module vec_elem_sequencer #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_ELE    = 32
) (
    input logic                clk,
    input logic                reset,
    vec_elem_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    localparam logic [ADDR_WIDTH:0]   NumEle = NUM_ELE[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   VlOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] IdxOne = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    state_e                state_q, state_d;
    logic [2:0]            op_q;
    logic [ADDR_WIDTH-1:0] vd_q, vs1_q, vs2_q, idx_q, widx_q;
    logic [ADDR_WIDTH:0]   vl_q, vl_eff;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  pipe_valid_q, done_q, err_q;
    logic                  accept, op_legal, last_elem;

    assign accept    = bus.cmd_valid && (state_q == StIdle);
    assign vl_eff    = (bus.cmd_vl > NumEle) ? NumEle : bus.cmd_vl;
    assign last_elem = (({1'b0, idx_q} + VlOne) == vl_q);

`ifdef VEC_SEQ_MUL_EN
    assign op_legal = 1'b1;
`else
    assign op_legal = (bus.cmd_op != 3'd5);
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept && (vl_eff != '0) && op_legal) state_d = StRun;
            StRun:   if (last_elem) state_d = StDrain;
            StDrain: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        res_d = '0;
        case (op_q)
            3'd0: res_d = bus.rf_rData1 + bus.rf_rData2;
            3'd1: res_d = bus.rf_rData1 - bus.rf_rData2;
            3'd2: res_d = bus.rf_rData1 & bus.rf_rData2;
            3'd3: res_d = bus.rf_rData1 | bus.rf_rData2;
            3'd4: res_d = bus.rf_rData1 ^ bus.rf_rData2;
`ifdef VEC_SEQ_MUL_EN
            3'd5: res_d = bus.rf_rData1 * bus.rf_rData2;
`endif
            3'd6: res_d = ($signed(bus.rf_rData1) < $signed(bus.rf_rData2)) ?
                          bus.rf_rData1 : bus.rf_rData2;
            3'd7: res_d = ($signed(bus.rf_rData1) > $signed(bus.rf_rData2)) ?
                          bus.rf_rData1 : bus.rf_rData2;
            default: res_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            op_q         <= '0;
            vd_q         <= '0;
            vs1_q        <= '0;
            vs2_q        <= '0;
            vl_q         <= '0;
            idx_q        <= '0;
            widx_q       <= '0;
            res_q        <= '0;
            pipe_valid_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pipe_valid_q <= (state_q == StRun);
            done_q       <= (state_q == StDrain);
            err_q        <= 1'b0;
            if (accept) begin
                op_q   <= bus.cmd_op;
                vd_q   <= bus.cmd_vd;
                vs1_q  <= bus.cmd_vs1;
                vs2_q  <= bus.cmd_vs2;
                vl_q   <= vl_eff;
                idx_q  <= '0;
                done_q <= (vl_eff == '0) || !op_legal;
                err_q  <= !op_legal;
            end
            // Writes trail reads by one cycle, so element k-1 is written while k is read.
            if (state_q == StRun) begin
                res_q  <= res_d;
                widx_q <= idx_q;
                if (!last_elem) idx_q <= idx_q + IdxOne;
            end
        end
    end

    assign bus.cmd_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = done_q;
    assign bus.err         = err_q;
    assign bus.rf_rAddr1_1 = vs1_q;
    assign bus.rf_rAddr2_1 = idx_q;
    assign bus.rf_rAddr1_2 = vs2_q;
    assign bus.rf_rAddr2_2 = idx_q;
    assign bus.rf_wAddr1   = vd_q;
    assign bus.rf_wAddr2   = widx_q;
    assign bus.rf_wData    = res_q;
    assign bus.rf_wEnable  = pipe_valid_q;
endmodule
